// File: rtl/gate_truth_checker_if.sv
// Bundles the run-control and result signals that pass between the gate checker and its environment.
// The master modport is the checker; the slave modport is the gate/bench side.
interface gate_truth_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_q;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, dut_q,
    output vec, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, dut_q,
    input  vec, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks every input vector of a combinational gate, samples its output after a settle
// delay and compares it to a truth table, keeping error count and first failing vector.
module gate_truth_checker #(
  parameter int                   N_IN     = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1000,
  parameter int                   SETTLE   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_truth_checker_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for start, outputs at reset values
  // DRIVE  | vec held on the gate, settle counter running
  // SAMPLE | one cycle, dut_q compared at the closing edge
  // DONE   | results held until start or reset
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = 1;
  localparam logic [N_IN:0]   ERR_ONE     = 1;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            mismatch;

  assign mismatch = (bus.dut_q != EXPECTED[vec_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // pass must also reflect the sample taken on this very edge
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;

endmodule
